// File: rtl/ascon_rx_pkg.sv
// ---------------------------------------------------------------------------
// ascon_rx_pkg
// Shared definitions for the Ascon decryption receive stage:
//   - rx_state_e : FSM state encoding (IDLE / COLLECT / RESULT)
//   - TAG_LEN    : authentication tag length in bits
//   - DEFAULT_Y  : default plaintext length in bits
//   - DEFAULT_CW : default bit-counter width (2**CW must exceed TAG_LEN)
// ---------------------------------------------------------------------------
package ascon_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESULT  = 2'd2
    } rx_state_e;

    localparam int TAG_LEN    = 128;
    localparam int DEFAULT_Y  = 80;
    localparam int DEFAULT_CW = 8;

endpackage

// File: rtl/ascon_tag_cmp.sv
// ---------------------------------------------------------------------------
// ascon_tag_cmp
// Serial constant-time tag comparator. One computed tag bit and the matching
// expected tag bit are presented per enabled cycle; any mismatch is
// OR-accumulated into a sticky difference flag, so the compare always takes
// the full tag length regardless of where (or whether) the tags differ.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr_i        clear the accumulated difference (start of a new tag)
//   en_i         accumulate the current bit pair on this edge
//   tag_bit_i    computed tag bit from the core
//   exp_bit_i    expected tag bit at the same index
//   diff_o       accumulated difference including the bit pair presented
//                now; at the final bit this is the complete compare result
// ---------------------------------------------------------------------------
module ascon_tag_cmp (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic tag_bit_i,
    input  logic exp_bit_i,
    output logic diff_o
);

    logic diff_q;
    logic diff_d;

    // Look-ahead value so the caller can latch the verdict on the same edge
    // that samples the last tag bit.
    assign diff_d = diff_q | (tag_bit_i ^ exp_bit_i);
    assign diff_o = diff_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q <= 1'b0;
        end else if (clr_i) begin
            diff_q <= 1'b0;
        end else if (en_i) begin
            diff_q <= diff_d;
        end
    end

endmodule

// File: rtl/ascon_dec_rx.sv
// ---------------------------------------------------------------------------
// ascon_dec_rx
// Receive stage behind the serial Ascon decryption core. Deserialises the
// LSB-first plaintext and tag streams, compares the tag against exp_tag_i in
// constant time, and releases the plaintext only when the tag matches.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   dec_ready_i    core ready flag; a rising edge starts a collection
//   pt_bit_i       serial plaintext bit (bit k in the k-th COLLECT cycle)
//   tag_bit_i      serial tag bit (same timing as the plaintext)
//   exp_tag_i      expected tag, stable for the whole operation
//   pt_o           verified plaintext, zero unless auth_ok_o
//   out_valid_o    result available
//   out_ready_i    consumer accepts the result
//   auth_ok_o      tag matched (qualified by out_valid_o)
//   auth_fail_o    tag mismatched (qualified by out_valid_o)
//   abort_o        one-cycle pulse when dec_ready_i drops mid-collection
//
// Handshake: the result (pt_o, auth_ok_o, auth_fail_o) is presented with
// out_valid_o and held unchanged until an edge with out_valid_o & out_ready_i;
// that edge consumes it and all result outputs return to zero. out_valid_o
// never depends combinationally on out_ready_i.
// ---------------------------------------------------------------------------
module ascon_dec_rx
    import ascon_rx_pkg::*;
#(
    parameter int Y  = DEFAULT_Y,
    parameter int T  = TAG_LEN,
    parameter int CW = DEFAULT_CW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dec_ready_i,
    input  logic         pt_bit_i,
    input  logic         tag_bit_i,
    input  logic [T-1:0] exp_tag_i,
    output logic [Y-1:0] pt_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         auth_ok_o,
    output logic         auth_fail_o,
    output logic         abort_o
);

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy_q;
    logic [Y-1:0]  pt_sh_q, pt_sh_d;
    logic [Y-1:0]  pt_q, pt_d;
    logic          valid_q, valid_d;
    logic          ok_q, ok_d;
    logic          fail_q, fail_d;
    logic          abort_q, abort_d;

    logic          start;
    logic          last_bit;
    logic          exp_bit;
    logic          cmp_clr;
    logic          cmp_en;
    logic          diff_final;

    // Only a fresh rising edge of the ready flag starts work; a level that
    // stays high after a consumed result must not restart the collection.
    assign start    = dec_ready_i & ~rdy_q;
    assign last_bit = (cnt_q == CW'(T - 1));
    assign exp_bit  = exp_tag_i[cnt_q[6:0]];

    ascon_tag_cmp u_tag_cmp (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cmp_clr),
        .en_i      (cmp_en),
        .tag_bit_i (tag_bit_i),
        .exp_bit_i (exp_bit),
        .diff_o    (diff_final)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (!dec_ready_i) begin
                    state_d = IDLE;
                end else if (last_bit) begin
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (valid_q && out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        pt_sh_d = pt_sh_q;
        pt_d    = pt_q;
        valid_d = valid_q;
        ok_d    = ok_q;
        fail_d  = fail_q;
        abort_d = 1'b0;
        cmp_clr = 1'b0;
        cmp_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    pt_sh_d = '0;
                    cmp_clr = 1'b1;
                end
            end
            COLLECT: begin
                if (dec_ready_i) begin
                    cmp_en = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                    // Indices >= Y carry a stale plaintext bit from the core
                    // and never match any position here, so they are dropped.
                    for (int i = 0; i < Y; i++) begin
                        if (cnt_q == CW'(i)) begin
                            pt_sh_d[i] = pt_bit_i;
                        end
                    end
                    if (last_bit) begin
                        // diff_final already folds in the bit sampled now, and
                        // pt_sh_d includes the last plaintext bit when Y == T.
                        valid_d = 1'b1;
                        ok_d    = ~diff_final;
                        fail_d  = diff_final;
                        pt_d    = diff_final ? '0 : pt_sh_d;
                    end
                end else begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    pt_sh_d = '0;
                end
            end
            RESULT: begin
                if (valid_q && out_ready_i) begin
                    valid_d = 1'b0;
                    ok_d    = 1'b0;
                    fail_d  = 1'b0;
                    pt_d    = '0;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            pt_sh_q <= '0;
            pt_q    <= '0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
            fail_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rdy_q   <= dec_ready_i;
            pt_sh_q <= pt_sh_d;
            pt_q    <= pt_d;
            valid_q <= valid_d;
            ok_q    <= ok_d;
            fail_q  <= fail_d;
            abort_q <= abort_d;
        end
    end

    assign pt_o        = pt_q;
    assign out_valid_o = valid_q;
    assign auth_ok_o   = ok_q;
    assign auth_fail_o = fail_q;
    assign abort_o     = abort_q;

endmodule

// File: tb/tb_ascon_dec_rx.sv
// ---------------------------------------------------------------------------
// tb_ascon_dec_rx
// Two receivers share one serial stream: dut_a (Y=80) and dut_b (Y=128).
// The transaction-level model says: after a full 128-bit stream the result
// appears, ok iff the streamed tag equals exp_tag_i, plaintext = the first Y
// streamed bits when ok, else zero; a dropped ready flag gives one abort pulse.
// ---------------------------------------------------------------------------
module tb_ascon_dec_rx;

    logic         clk;
    logic         rst;
    logic         dec_ready_i;
    logic         pt_bit_i;
    logic         tag_bit_i;
    logic [127:0] exp_tag_i;
    logic         out_ready_i;

    logic [79:0]  a_pt_o;
    logic         a_out_valid_o, a_auth_ok_o, a_auth_fail_o, a_abort_o;
    logic [127:0] b_pt_o;
    logic         b_out_valid_o, b_auth_ok_o, b_auth_fail_o, b_abort_o;

    // Model state
    logic         m_valid, m_ok, m_fail, m_abort;
    logic [79:0]  m_pt80;
    logic [127:0] m_pt128;
    logic         chk_on;

    int n_checks;
    int n_errors;
    int abort_cnt;

    ascon_dec_rx #(.Y(80)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .dec_ready_i (dec_ready_i),
        .pt_bit_i    (pt_bit_i),
        .tag_bit_i   (tag_bit_i),
        .exp_tag_i   (exp_tag_i),
        .pt_o        (a_pt_o),
        .out_valid_o (a_out_valid_o),
        .out_ready_i (out_ready_i),
        .auth_ok_o   (a_auth_ok_o),
        .auth_fail_o (a_auth_fail_o),
        .abort_o     (a_abort_o)
    );

    ascon_dec_rx #(.Y(128)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .dec_ready_i (dec_ready_i),
        .pt_bit_i    (pt_bit_i),
        .tag_bit_i   (tag_bit_i),
        .exp_tag_i   (exp_tag_i),
        .pt_o        (b_pt_o),
        .out_valid_o (b_out_valid_o),
        .out_ready_i (out_ready_i),
        .auth_ok_o   (b_auth_ok_o),
        .auth_fail_o (b_auth_fail_o),
        .abort_o     (b_abort_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0;
        m_ok    = 1'b0;
        m_fail  = 1'b0;
        m_abort = 1'b0;
        m_pt80  = '0;
        m_pt128 = '0;
    endtask

    // Per-cycle compare of both DUTs against the model, away from the edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_valid", a_out_valid_o, m_valid);
            chk("a_ok",    a_auth_ok_o,   m_ok);
            chk("a_fail",  a_auth_fail_o, m_fail);
            chk("a_abort", a_abort_o,     m_abort);
            chk("a_pt",    a_pt_o,        m_pt80);
            chk("b_valid", b_out_valid_o, m_valid);
            chk("b_ok",    b_auth_ok_o,   m_ok);
            chk("b_fail",  b_auth_fail_o, m_fail);
            chk("b_abort", b_abort_o,     m_abort);
            chk("b_pt",    b_pt_o,        m_pt128);
        end
    end

    always @(negedge clk) begin
        if (a_abort_o === 1'b1) abort_cnt++;
    end

    // ---------------- driver tasks ----------------
    // Entered and left at 1 time unit after a rising edge. Raises the ready
    // flag, streams nbits LSB-first; nbits < 128 drops ready (abort case).
    task automatic run_txn(input logic [127:0] pt, input logic [127:0] tag,
                           input logic [127:0] exp, input int nbits, output int lat);
        lat = 0;
        exp_tag_i   = exp;
        dec_ready_i = 1'b1;
        @(posedge clk); #1;                       // edge 1 detects the rise
        for (int k = 0; k < nbits; k++) begin
            pt_bit_i  = pt[k];
            tag_bit_i = tag[k];
            @(posedge clk); #1;                   // edge k+2 samples bit k
            if (a_out_valid_o && lat == 0) lat = k + 2;
        end
        pt_bit_i  = 1'($urandom_range(0, 1));
        tag_bit_i = 1'($urandom_range(0, 1));
        if (nbits < 128) begin
            dec_ready_i = 1'b0;
            @(posedge clk); #1;
            m_abort = 1'b1;
            @(posedge clk); #1;
            m_abort = 1'b0;
        end else begin
            m_valid = 1'b1;
            m_ok    = (tag == exp);
            m_fail  = (tag != exp);
            m_pt80  = m_ok ? pt[79:0] : 80'd0;
            m_pt128 = m_ok ? pt : 128'd0;
        end
    endtask

    // Hold the result for 'hold' cycles, consume it, then keep ready high to
    // show no restart, then drop ready.
    task automatic ack(input int hold);
        for (int i = 0; i < hold; i++) begin
            pt_bit_i  = 1'($urandom_range(0, 1));
            tag_bit_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        model_clear();
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("stale_no_restart", a_out_valid_o, 1'b0);
        dec_ready_i = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [127:0] pt, tag, tag_a;
    int lat;

    initial begin
        n_checks = 0; n_errors = 0; abort_cnt = 0;
        chk_on = 1'b0;
        rst = 1'b0; dec_ready_i = 1'b0; pt_bit_i = 1'b0; tag_bit_i = 1'b0;
        exp_tag_i = '0; out_ready_i = 1'b0;
        model_clear();
        tag_a = 128'hFEDCBA98765432100F1E2D3C4B5A6978;

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_valid", a_out_valid_o, 1'b0);
        chk("rst_ok",    a_auth_ok_o,   1'b0);
        chk("rst_fail",  a_auth_fail_o, 1'b0);
        chk("rst_abort", a_abort_o,     1'b0);
        chk("rst_pt",    a_pt_o,        80'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk_on = 1'b1;
        @(posedge clk); #1;

        // Matching tag
        pt = {48'hA5A55A5AC3C3, 80'h0123456789ABCDEF0123};
        run_txn(pt, tag_a, tag_a, 128, lat);
        chk("match_latency", 128'(lat), 128'd129);
        chk("match_ok",      a_auth_ok_o, 1'b1);
        chk("match_pt80",    a_pt_o, 80'h0123456789ABCDEF0123);
        chk("match_pt128",   b_pt_o, 128'hA5A55A5AC3C30123456789ABCDEF0123);
        ack(2);

        // Single-bit mismatch in tag bit 127, same latency
        tag = tag_a;
        tag[127] = ~tag[127];
        run_txn(pt, tag, tag_a, 128, lat);
        chk("mismatch_latency", 128'(lat), 128'd129);
        chk("mismatch_fail",    a_auth_fail_o, 1'b1);
        chk("mismatch_ok",      a_auth_ok_o, 1'b0);
        chk("mismatch_pt80",    a_pt_o, 80'd0);
        chk("mismatch_pt128",   b_pt_o, 128'd0);
        ack(1);

        // Backpressure: hold 20 cycles
        pt = {48'h0F0F0F0F0F0F, 80'hDEADBEEFCAFEF00D1234};
        run_txn(pt, tag_a, tag_a, 128, lat);
        ack(20);
        chk("bp_cleared_pt", a_pt_o, 80'd0);

        // Abort after 50 bits, then a full valid stream
        run_txn(pt, tag_a, tag_a, 50, lat);
        chk("abort_pulses", 128'(abort_cnt), 128'd1);
        chk("abort_no_valid", a_out_valid_o, 1'b0);
        pt = {48'h123456789ABC, 80'h0123456789ABCDEF0123};
        run_txn(pt, tag_a, tag_a, 128, lat);
        chk("post_abort_ok", a_auth_ok_o, 1'b1);
        chk("post_abort_pt", a_pt_o, 80'h0123456789ABCDEF0123);
        ack(0);

        // Async reset mid-collection (bit 60)
        exp_tag_i   = tag_a;
        dec_ready_i = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 60; k++) begin
            pt_bit_i  = pt[k];
            tag_bit_i = tag_a[k];
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        dec_ready_i = 1'b0;
        #1;
        chk("rst_collect_valid", a_out_valid_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        pt = {48'hFFFF0000FFFF, 80'h55AA55AA55AA55AA55AA};
        run_txn(pt, tag_a, tag_a, 128, lat);
        chk("post_rst_ok", a_auth_ok_o, 1'b1);
        chk("post_rst_pt", a_pt_o, 80'h55AA55AA55AA55AA55AA);
        ack(0);

        // Async reset while a result is held: outputs clear before any edge
        run_txn(pt, tag_a, tag_a, 128, lat);
        #2 rst = 1'b1;
        dec_ready_i = 1'b0;
        model_clear();
        #1;
        chk("async_rst_valid", a_out_valid_o, 1'b0);
        chk("async_rst_ok",    a_auth_ok_o,   1'b0);
        chk("async_rst_pt",    a_pt_o,        80'd0);
        chk("async_rst_pt128", b_pt_o,        128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // All-ones 128-bit plaintext on the Y=128 build
        pt = '1;
        run_txn(pt, tag_a, tag_a, 128, lat);
        chk("ones_pt128", b_pt_o, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF);
        chk("ones_ok128", b_auth_ok_o, 1'b1);
        chk("ones_pt80",  a_pt_o, 80'hFFFFFFFFFFFFFFFFFFFF);
        ack(3);

        chk("final_abort_pulses", 128'(abort_cnt), 128'd1);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
